// File: rtl/s2a_controller.sv
// Stream-to-AXI write controller: packs stream words into a 32-word ping-pong
// buffer and drains each filled 16-word half as one 16-beat AXI write burst.
module s2a_controller (
  input  logic        AXI_clk,
  input  logic        rst_n,
  input  logic        sync,
  input  logic        Ien,
  input  logic [31:0] Idata,
  input  logic [31:0] ibase,
  input  logic [23:6] isize,
  output logic [23:6] iacnt,
  output logic [31:0] ibcnt,
  output logic [31:0] AXI_awaddr,
  output logic        AXI_awvalid,
  input  logic        AXI_awready,
  output logic [3:0]  AXI_awlen,
  output logic [31:0] AXI_wdata,
  output logic        AXI_wvalid,
  input  logic        AXI_wready,
  output logic        AXI_wlast,
  input  logic        AXI_bvalid,
  output logic        AXI_bready,
  input  logic [1:0]  AXI_bresp,
  output logic        s2a_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem [32];
  logic [4:0]        wptr_q, wptr_d;
  logic [1:0]        full_q, full_d;
  logic [1:0][25:0]  blkAddr_q, blkAddr_d;
  logic [23:6]       iacnt_q, iacnt_d;
  logic [31:0]       ibcnt_q, ibcnt_d;
  logic              err_q, err_d;
  logic              flush_q, flush_d;
  logic              rdHalf_q, rdHalf_d;
  logic [3:0]        beat_q, beat_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              wvalid_q, wvalid_d;
  logic              wlast_q, wlast_d;
  logic              bready_q, bready_d;

  logic              wrHalf;
  logic              wrAccept;
  logic              wrDrop;
  logic              halfDone;
  logic              unusedIbase;

  // Only 64-byte aligned block addresses are produced.
  assign unusedIbase = ^ibase[5:0];

  // Overflow is judged on the registered full bit, so a half being released
  // this cycle still rejects a word aimed at it.
  assign wrHalf   = wptr_q[4];
  assign wrAccept = Ien && !sync && !full_q[wrHalf];
  assign wrDrop   = Ien && !sync && full_q[wrHalf];
  assign halfDone = wrAccept && (wptr_q[3:0] == 4'hf);

  always_ff @(posedge AXI_clk) begin
    if (wrAccept) begin
      mem[wptr_q] <= Idata;
    end
  end

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    full_d    = full_q;
    blkAddr_d = blkAddr_q;
    iacnt_d   = iacnt_q;
    ibcnt_d   = ibcnt_q;
    err_d     = err_q;
    flush_d   = flush_q;
    rdHalf_d  = rdHalf_q;
    beat_d    = beat_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wvalid_d  = wvalid_q;
    wlast_d   = wlast_q;
    bready_d  = bready_q;

    if (wrAccept) begin
      wptr_d = wptr_q + 5'd1;
    end
    if (wrDrop) begin
      err_d = 1'b1;
    end
    if (halfDone) begin
      full_d[wrHalf]    = 1'b1;
      blkAddr_d[wrHalf] = ibase[31:6] + {8'd0, iacnt_q};
      if (iacnt_q == isize - 18'd1) begin
        iacnt_d = '0;
        ibcnt_d = ibcnt_q + 32'd1;
      end else begin
        iacnt_d = iacnt_q + 18'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (full_q[rdHalf_q] && !sync) begin
          awaddr_d  = {blkAddr_q[rdHalf_q], 6'b0};
          awvalid_d = 1'b1;
          state_d   = ADDR;
        end
      end
      ADDR: begin
        if (AXI_awready) begin
          awvalid_d = 1'b0;
          beat_d    = 4'd0;
          wvalid_d  = 1'b1;
          wlast_d   = 1'b0;
          wdata_d   = mem[{rdHalf_q, 4'd0}];
          state_d   = DATA;
        end
      end
      DATA: begin
        if (AXI_wready) begin
          if (beat_q == 4'd15) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            state_d  = RESP;
          end else begin
            beat_d  = beat_q + 4'd1;
            wdata_d = mem[{rdHalf_q, beat_q + 4'd1}];
            wlast_d = (beat_q == 4'd14);
          end
        end
      end
      RESP: begin
        // A flushed burst belongs to the stream before the restart.
        if (AXI_bvalid) begin
          bready_d = 1'b0;
          state_d  = IDLE;
          if (flush_q) begin
            flush_d = 1'b0;
          end else begin
            full_d[rdHalf_q] = 1'b0;
            rdHalf_d         = ~rdHalf_q;
            if (AXI_bresp != 2'b00) begin
              err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (sync) begin
      wptr_d   = '0;
      iacnt_d  = '0;
      ibcnt_d  = '0;
      full_d   = '0;
      err_d    = 1'b0;
      rdHalf_d = 1'b0;
      if (state_q != IDLE && !(state_q == RESP && AXI_bvalid)) begin
        flush_d = 1'b1;
      end
    end
  end

  always_ff @(posedge AXI_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      full_q    <= '0;
      blkAddr_q <= '0;
      iacnt_q   <= '0;
      ibcnt_q   <= '0;
      err_q     <= 1'b0;
      flush_q   <= 1'b0;
      rdHalf_q  <= 1'b0;
      beat_q    <= '0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wvalid_q  <= 1'b0;
      wlast_q   <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      full_q    <= full_d;
      blkAddr_q <= blkAddr_d;
      iacnt_q   <= iacnt_d;
      ibcnt_q   <= ibcnt_d;
      err_q     <= err_d;
      flush_q   <= flush_d;
      rdHalf_q  <= rdHalf_d;
      beat_q    <= beat_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      wlast_q   <= wlast_d;
      bready_q  <= bready_d;
    end
  end

  assign iacnt       = iacnt_q;
  assign ibcnt       = ibcnt_q;
  assign AXI_awaddr  = awaddr_q;
  assign AXI_awvalid = awvalid_q;
  assign AXI_awlen   = 4'hf;
  assign AXI_wdata   = wdata_q;
  assign AXI_wvalid  = wvalid_q;
  assign AXI_wlast   = wlast_q;
  assign AXI_bready  = bready_q;
  assign s2a_err     = err_q;

endmodule

// File: tb/tb_s2a_controller.sv
// Directed bench for s2a_controller: a small AXI slave responder, a bus monitor
// collecting handshakes, and one task per scenario with hand-computed results.
module tb_s2a_controller;

  logic        AXI_clk = 1'b0;
  logic        rst_n;
  logic        sync;
  logic        Ien;
  logic [31:0] Idata;
  logic [31:0] ibase;
  logic [23:6] isize;
  logic [23:6] iacnt;
  logic [31:0] ibcnt;
  logic [31:0] AXI_awaddr;
  logic        AXI_awvalid;
  logic        AXI_awready;
  logic [3:0]  AXI_awlen;
  logic [31:0] AXI_wdata;
  logic        AXI_wvalid;
  logic        AXI_wready = 1'b1;
  logic        AXI_wlast;
  logic        AXI_bvalid = 1'b0;
  logic        AXI_bready;
  logic [1:0]  AXI_bresp;
  logic        s2a_err;

  int compared = 0;
  int mismatched = 0;

  bit          wToggle = 1'b0;
  int          bDelay = 0;
  int          bCnt = 0;
  int          bCount = 0;
  int          stableErr = 0;
  logic [31:0] awQ[$];
  logic [31:0] wQ[$];
  logic        wlQ[$];
  bit          awStallPrev = 1'b0;
  bit          wStallPrev = 1'b0;
  bit          bStallPrev = 1'b0;
  logic [31:0] awAddrPrev = '0;
  logic [31:0] wDataPrev = '0;
  logic        wLastPrev = 1'b0;

  s2a_controller dut (
    .AXI_clk     (AXI_clk),
    .rst_n       (rst_n),
    .sync        (sync),
    .Ien         (Ien),
    .Idata       (Idata),
    .ibase       (ibase),
    .isize       (isize),
    .iacnt       (iacnt),
    .ibcnt       (ibcnt),
    .AXI_awaddr  (AXI_awaddr),
    .AXI_awvalid (AXI_awvalid),
    .AXI_awready (AXI_awready),
    .AXI_awlen   (AXI_awlen),
    .AXI_wdata   (AXI_wdata),
    .AXI_wvalid  (AXI_wvalid),
    .AXI_wready  (AXI_wready),
    .AXI_wlast   (AXI_wlast),
    .AXI_bvalid  (AXI_bvalid),
    .AXI_bready  (AXI_bready),
    .AXI_bresp   (AXI_bresp),
    .s2a_err     (s2a_err)
  );

  always #5 AXI_clk = ~AXI_clk;

  // Slave side: W ready either constant or toggling; B arrives bDelay cycles after bready.
  always @(posedge AXI_clk) begin
    #1;
    if (wToggle) AXI_wready = ~AXI_wready;
    else AXI_wready = 1'b1;
    if (!rst_n) begin
      AXI_bvalid = 1'b0;
      bCnt = 0;
    end else if (AXI_bvalid) begin
      if (!AXI_bready) AXI_bvalid = 1'b0;
    end else if (AXI_bready) begin
      if (bCnt >= bDelay) begin
        AXI_bvalid = 1'b1;
        bCnt = 0;
      end else begin
        bCnt++;
      end
    end
  end

  // Record handshakes mid-cycle and flag any payload change while stalled.
  always @(negedge AXI_clk) begin
    if (rst_n) begin
      if (awStallPrev && (AXI_awvalid !== 1'b1 || AXI_awaddr !== awAddrPrev)) stableErr++;
      if (wStallPrev && (AXI_wvalid !== 1'b1 || AXI_wdata !== wDataPrev || AXI_wlast !== wLastPrev)) stableErr++;
      if (bStallPrev && AXI_bready !== 1'b1) stableErr++;
      if (AXI_awvalid && AXI_awready) awQ.push_back(AXI_awaddr);
      if (AXI_wvalid && AXI_wready) begin
        wQ.push_back(AXI_wdata);
        wlQ.push_back(AXI_wlast);
      end
      if (AXI_bvalid && AXI_bready) bCount++;
      awStallPrev = AXI_awvalid && !AXI_awready;
      wStallPrev  = AXI_wvalid && !AXI_wready;
      bStallPrev  = AXI_bready && !AXI_bvalid;
      awAddrPrev  = AXI_awaddr;
      wDataPrev   = AXI_wdata;
      wLastPrev   = AXI_wlast;
    end else begin
      awStallPrev = 1'b0;
      wStallPrev  = 1'b0;
      bStallPrev  = 1'b0;
    end
  end

  task automatic sendWords(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      Ien = 1'b1;
      Idata = 32'(start + i);
      @(posedge AXI_clk);
      #1;
    end
    Ien = 1'b0;
  endtask

  task automatic pulseSync();
    sync = 1'b1;
    @(posedge AXI_clk);
    #1;
    sync = 1'b0;
  endtask

  task automatic waitBursts(input int target, output bit ok);
    int n;
    n = 0;
    while (bCount < target && n < 400) begin
      @(posedge AXI_clk);
      #1;
      n++;
    end
    ok = (bCount >= target);
  endtask

  task automatic clearQueues();
    awQ.delete();
    wQ.delete();
    wlQ.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sync = 1'b0;
    Ien = 1'b0;
    Idata = '0;
    ibase = 32'h1000_0000;
    isize = 18'd4;
    AXI_awready = 1'b1;
    AXI_bresp = 2'b00;
    repeat (3) @(posedge AXI_clk);
    #1;
    compared++;
    if ({AXI_awvalid, AXI_wvalid, AXI_wlast, AXI_bready, s2a_err} !== 5'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {AXI_awvalid, AXI_wvalid, AXI_wlast, AXI_bready, s2a_err});
    end
    compared++;
    if (AXI_awlen !== 4'hf) begin
      mismatched++;
      $display("[TB] FAIL reset_awlen: got %h expected f", AXI_awlen);
    end
    compared++;
    if ({AXI_awaddr, AXI_wdata, ibcnt} !== 96'd0 || iacnt !== 18'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_data: awaddr %h wdata %h ibcnt %h iacnt %h expected all 0", AXI_awaddr, AXI_wdata, ibcnt, iacnt);
    end
    rst_n = 1'b1;
    @(posedge AXI_clk);
    #1;
  endtask

  task automatic test_two_bursts();
    int startB;
    bit ok;
    clearQueues();
    startB = bCount;
    ibase = 32'h1000_0000;
    isize = 18'd4;
    sendWords(0, 16);
    compared++;
    if (AXI_awvalid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL awvalid_fill_edge: got %b expected 0", AXI_awvalid);
    end
    @(posedge AXI_clk);
    #1;
    compared++;
    if (AXI_awvalid !== 1'b1 || AXI_awaddr !== 32'h1000_0000) begin
      mismatched++;
      $display("[TB] FAIL awvalid_next_edge: got %b/%h expected 1/10000000", AXI_awvalid, AXI_awaddr);
    end
    sendWords(16, 16);
    waitBursts(startB + 2, ok);
    compared++;
    if (ok !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL basic_timeout: responses %0d expected 2", bCount - startB);
    end
    compared++;
    if (awQ.size() != 2 || awQ[0] !== 32'h1000_0000 || awQ[1] !== 32'h1000_0040) begin
      mismatched++;
      $display("[TB] FAIL basic_addr: got %0d bursts, first %h, expected 2 at 10000000/10000040", awQ.size(), awQ.size() > 0 ? awQ[0] : 32'hx);
    end
    compared++;
    if (wQ.size() != 32) begin
      mismatched++;
      $display("[TB] FAIL basic_beats: got %0d expected 32", wQ.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        compared++;
        if (wQ[i] !== 32'(i) || wlQ[i] !== (i % 16 == 15)) begin
          mismatched++;
          $display("[TB] FAIL basic_beat%0d: got %h/%b expected %h/%b", i, wQ[i], wlQ[i], i, (i % 16 == 15));
        end
      end
    end
    compared++;
    if (iacnt !== 18'd2 || ibcnt !== 32'd0 || s2a_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_counts: iacnt %0d ibcnt %0d err %b expected 2 0 0", iacnt, ibcnt, s2a_err);
    end
  endtask

  task automatic test_wrap();
    int startB;
    bit ok;
    logic [31:0] expAddr [4];
    expAddr = '{32'hFFFF_FFC0, 32'h0000_0000, 32'hFFFF_FFC0, 32'h0000_0000};
    pulseSync();
    clearQueues();
    startB = bCount;
    ibase = 32'hFFFF_FFC5;
    isize = 18'd2;
    sendWords(0, 32);
    waitBursts(startB + 2, ok);
    sendWords(32, 32);
    waitBursts(startB + 4, ok);
    compared++;
    if (ok !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wrap_timeout: responses %0d expected 4", bCount - startB);
    end
    compared++;
    if (awQ.size() != 4) begin
      mismatched++;
      $display("[TB] FAIL wrap_bursts: got %0d expected 4", awQ.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        compared++;
        if (awQ[i] !== expAddr[i]) begin
          mismatched++;
          $display("[TB] FAIL wrap_addr%0d: got %h expected %h", i, awQ[i], expAddr[i]);
        end
      end
    end
    compared++;
    if (wQ.size() != 64 || wQ[63] !== 32'd63 || wQ[40] !== 32'd40) begin
      mismatched++;
      $display("[TB] FAIL wrap_data: %0d beats, expected 64 ending in 63", wQ.size());
    end
    compared++;
    if (ibcnt !== 32'd2 || iacnt !== 18'd0) begin
      mismatched++;
      $display("[TB] FAIL wrap_counts: ibcnt %0d iacnt %0d expected 2 0", ibcnt, iacnt);
    end
  endtask

  task automatic test_overflow();
    int startB;
    bit ok;
    pulseSync();
    clearQueues();
    startB = bCount;
    ibase = 32'h1000_0000;
    isize = 18'd4;
    AXI_awready = 1'b0;
    sendWords(0, 48);
    compared++;
    if (s2a_err !== 1'b1 || AXI_awvalid !== 1'b1 || awQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL ovf_stall: err %b awvalid %b aw %0d expected 1 1 0", s2a_err, AXI_awvalid, awQ.size());
    end
    AXI_awready = 1'b1;
    waitBursts(startB + 2, ok);
    repeat (30) @(posedge AXI_clk);
    #1;
    compared++;
    if (ok !== 1'b1 || awQ.size() != 2) begin
      mismatched++;
      $display("[TB] FAIL ovf_bursts: got %0d expected 2", awQ.size());
    end
    compared++;
    if (wQ.size() != 32 || wQ[16] !== 32'd16 || wQ[31] !== 32'd31 || awQ[1] !== 32'h1000_0040) begin
      mismatched++;
      $display("[TB] FAIL ovf_data: %0d beats expected 32 with data 0..31", wQ.size());
    end
    compared++;
    if (stableErr !== 0 || iacnt !== 18'd2) begin
      mismatched++;
      $display("[TB] FAIL ovf_stable: stall changes %0d iacnt %0d expected 0 2", stableErr, iacnt);
    end
  endtask

  task automatic test_stall();
    int startB;
    int n;
    bit ok;
    pulseSync();
    clearQueues();
    startB = bCount;
    wToggle = 1'b1;
    bDelay = 10;
    sendWords(0, 32);
    n = 0;
    while (AXI_bready !== 1'b1 && n < 200) begin
      @(posedge AXI_clk);
      #1;
      n++;
    end
    compared++;
    if (AXI_bready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stall_bready: got %b expected 1", AXI_bready);
    end
    sendWords(32'hDEAD, 1);
    compared++;
    if (s2a_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stall_full_held: err %b expected 1", s2a_err);
    end
    waitBursts(startB + 2, ok);
    sendWords(100, 16);
    waitBursts(startB + 3, ok);
    compared++;
    if (ok !== 1'b1 || awQ.size() != 3 || awQ[2] !== 32'h1000_0080) begin
      mismatched++;
      $display("[TB] FAIL stall_bursts: got %0d bursts expected 3, third at 10000080", awQ.size());
    end
    compared++;
    if (wQ.size() != 48) begin
      mismatched++;
      $display("[TB] FAIL stall_beats: got %0d expected 48", wQ.size());
    end else begin
      for (int i = 0; i < 48; i++) begin
        compared++;
        if (wQ[i] !== ((i < 32) ? 32'(i) : 32'(68 + i))) begin
          mismatched++;
          $display("[TB] FAIL stall_beat%0d: got %h expected %h", i, wQ[i], (i < 32) ? 32'(i) : 32'(68 + i));
        end
      end
    end
    compared++;
    if (stableErr !== 0) begin
      mismatched++;
      $display("[TB] FAIL stall_stable: got %0d changes expected 0", stableErr);
    end
    wToggle = 1'b0;
    bDelay = 0;
    @(posedge AXI_clk);
    #1;
  endtask

  task automatic test_bresp_sync();
    int startB;
    bit ok;
    pulseSync();
    startB = bCount;
    isize = 18'd1;
    AXI_bresp = 2'b10;
    sendWords(0, 16);
    compared++;
    if (ibcnt !== 32'd1 || iacnt !== 18'd0 || s2a_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bresp_pre: ibcnt %0d iacnt %0d err %b expected 1 0 0", ibcnt, iacnt, s2a_err);
    end
    waitBursts(startB + 1, ok);
    AXI_bresp = 2'b00;
    compared++;
    if (ok !== 1'b1 || s2a_err !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bresp_err: err %b expected 1", s2a_err);
    end
    pulseSync();
    compared++;
    if (s2a_err !== 1'b0 || ibcnt !== 32'd0 || iacnt !== 18'd0) begin
      mismatched++;
      $display("[TB] FAIL bresp_sync: err %b ibcnt %0d iacnt %0d expected 0 0 0", s2a_err, ibcnt, iacnt);
    end
  endtask

  task automatic test_sync_mid_burst();
    int startB;
    int n;
    bit ok;
    pulseSync();
    clearQueues();
    startB = bCount;
    ibase = 32'h3000_0000;
    isize = 18'd4;
    sendWords(0, 16);
    waitBursts(startB + 1, ok);
    sendWords(16, 16);
    n = 0;
    while (wQ.size() < 21 && n < 100) begin
      @(posedge AXI_clk);
      #1;
      n++;
    end
    pulseSync();
    AXI_bresp = 2'b11;
    compared++;
    if (iacnt !== 18'd0 || AXI_wvalid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midsync_state: iacnt %0d wvalid %b expected 0 1", iacnt, AXI_wvalid);
    end
    sendWords(200, 16);
    waitBursts(startB + 2, ok);
    AXI_bresp = 2'b00;
    waitBursts(startB + 3, ok);
    compared++;
    if (ok !== 1'b1 || awQ.size() != 3 || awQ[0] !== 32'h3000_0000 || awQ[1] !== 32'h3000_0040 || awQ[2] !== 32'h3000_0000) begin
      mismatched++;
      $display("[TB] FAIL midsync_addr: got %0d bursts expected 3 at 30000000/30000040/30000000", awQ.size());
    end
    compared++;
    if (wQ.size() != 48) begin
      mismatched++;
      $display("[TB] FAIL midsync_beats: got %0d expected 48", wQ.size());
    end else begin
      for (int i = 0; i < 48; i++) begin
        compared++;
        if (wlQ[i] !== (i % 16 == 15) || (i >= 32 && wQ[i] !== 32'(168 + i))) begin
          mismatched++;
          $display("[TB] FAIL midsync_beat%0d: got %h/%b expected %h/%b", i, wQ[i], wlQ[i], 168 + i, (i % 16 == 15));
        end
      end
    end
    compared++;
    if (s2a_err !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL midsync_err: got %b expected 0", s2a_err);
    end
  endtask

  task automatic test_async_reset();
    int n;
    pulseSync();
    sendWords(32'h55, 16);
    n = 0;
    while (AXI_wvalid !== 1'b1 && n < 20) begin
      @(posedge AXI_clk);
      #1;
      n++;
    end
    compared++;
    if (AXI_wvalid !== 1'b1 || iacnt !== 18'd1) begin
      mismatched++;
      $display("[TB] FAIL arst_pre: wvalid %b iacnt %0d expected 1 1", AXI_wvalid, iacnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({AXI_awvalid, AXI_wvalid, AXI_wlast, AXI_bready, s2a_err} !== 5'b0 || AXI_awlen !== 4'hf) begin
      mismatched++;
      $display("[TB] FAIL arst_ctrl: got %b/%h expected 00000/f", {AXI_awvalid, AXI_wvalid, AXI_wlast, AXI_bready, s2a_err}, AXI_awlen);
    end
    compared++;
    if (AXI_wdata !== 32'd0 || AXI_awaddr !== 32'd0 || iacnt !== 18'd0 || ibcnt !== 32'd0) begin
      mismatched++;
      $display("[TB] FAIL arst_data: wdata %h awaddr %h iacnt %0d ibcnt %0d expected all 0", AXI_wdata, AXI_awaddr, iacnt, ibcnt);
    end
    @(posedge AXI_clk);
    #1;
    rst_n = 1'b1;
    @(posedge AXI_clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_wrap();
    test_overflow();
    test_stall();
    test_bresp_sync();
    test_sync_mid_burst();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
